// File: rtl/shift_deserializer.sv
// Serial-to-parallel word capture with selectable bit order and handshake hold.
// Define DESER_PARITY_EN to take an even-parity bit after each word and flag mismatches.
module shift_deserializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         shift_left,
    input  logic         bit_valid,
    input  logic         bit_in,
    input  logic         out_ready,
    output logic [W-1:0] Q,
    output logic         out_valid,
    output logic         busy,
    output logic         parity_err
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
`ifdef DESER_PARITY_EN
    localparam logic [1:0] S_PARITY  = 2'd2;
`endif
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]    r_state;
    logic [W-1:0]  r_sreg;
    logic [CW-1:0] r_cnt;
    logic          r_msb;
    logic [W-1:0]  w_shift;

    always_comb begin
        w_shift = r_msb ? {r_sreg[W-2:0], bit_in} : {bit_in, r_sreg[W-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_msb   <= 1'b0;
            Q       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sreg  <= '0;
                        r_cnt   <= '0;
                        r_msb   <= shift_left;
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // start outranks a coincident bit: the capture restarts and the bit is dropped
                    if (start) begin
                        r_sreg  <= '0;
                        r_cnt   <= '0;
                        r_msb   <= shift_left;
                    end else if (bit_valid) begin
                        r_sreg <= w_shift;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            Q <= w_shift;
`ifdef DESER_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_HOLD;
`endif
                        end
                    end
                end
`ifdef DESER_PARITY_EN
                S_PARITY: begin
                    if (start) begin
                        r_sreg  <= '0;
                        r_cnt   <= '0;
                        r_msb   <= shift_left;
                        r_state <= S_COLLECT;
                    end else if (bit_valid) begin
                        r_state <= S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == S_HOLD);
`ifdef DESER_PARITY_EN
    assign busy = (r_state == S_COLLECT) || (r_state == S_PARITY);

    logic r_perr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perr <= 1'b0;
        end else if (r_state == S_PARITY && !start && bit_valid) begin
            r_perr <= (^Q) ^ bit_in;
        end else if (r_state == S_IDLE && start) begin
            r_perr <= 1'b0;
        end
    end
    assign parity_err = r_perr;
`else
    assign busy       = (r_state == S_COLLECT);
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer: expected words queued at stimulus, checked in HOLD.
module tb_shift_deserializer;

    localparam int W = 8;
`ifdef DESER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, shift_left = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, out_ready = 1'b0;
    logic [W-1:0] Q;
    logic out_valid, busy, parity_err;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic         exp_p[$];
    logic [W-1:0] ew;
    logic         ep;

    shift_deserializer #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .shift_left(shift_left),
        .bit_valid(bit_valid), .bit_in(bit_in), .out_ready(out_ready),
        .Q(Q), .out_valid(out_valid), .busy(busy), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_word(input logic msb);
        start = 1'b1;
        shift_left = msb;
        tick();
        start = 1'b0;
    endtask

    // seq[W-1] is the first bit on the wire
    task automatic send_bits(input logic [W-1:0] seq, input int gap);
        for (int i = W - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in = seq[i];
            tick();
            bit_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic send_parity(input logic pbit);
        if (PAR) begin
            bit_valid = 1'b1;
            bit_in = pbit;
            tick();
            bit_valid = 1'b0;
        end
    endtask

    task automatic capture(input logic [W-1:0] seq, input logic msb, input int gap, input logic pbit);
        exp_q.push_back(msb ? seq : rev(seq));
        exp_p.push_back(PAR ? ((^seq) ^ pbit) : 1'b0);
        begin_word(msb);
        send_bits(seq, gap);
        send_parity(pbit);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++; if (Q !== '0) begin bad++; $display("FAIL reset_q got=%h exp=00", Q); end
        total++; if ({out_valid, busy, parity_err} !== 3'b000)
            begin bad++; $display("FAIL reset_flags got=%b exp=000", {out_valid, busy, parity_err}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_msb();
        capture(8'b10110010, 1'b1, 0, 1'b0);
        ew = exp_q.pop_front(); ep = exp_p.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL msb_valid got=%b exp=1", out_valid); end
        total++; if (Q !== ew) begin bad++; $display("FAIL msb_q got=%h exp=%h", Q, ew); end
        total++; if (parity_err !== ep) begin bad++; $display("FAIL msb_perr got=%b exp=%b", parity_err, ep); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_lsb();
        capture(8'b10110010, 1'b0, 0, 1'b0);
        ew = exp_q.pop_front(); ep = exp_p.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid got=%b exp=1", out_valid); end
        total++; if (Q !== ew) begin bad++; $display("FAIL lsb_q got=%h exp=%h", Q, ew); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_gaps_hold();
        begin_word(1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=%b exp=1", busy); end
        exp_q.push_back(8'h96);
        exp_p.push_back(1'b0);
        send_bits(8'h96, 2);
        send_parity(1'b0);
        ew = exp_q.pop_front(); ep = exp_p.pop_front();
        // start and bit_valid are toggled while holding; neither may disturb the word
        for (int c = 0; c < 5; c++) begin
            start = c[0]; bit_valid = 1'b1; bit_in = ~c[0];
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c=%0d got=%b exp=1", c, out_valid); end
            total++; if (Q !== ew) begin bad++; $display("FAIL hold_q c=%0d got=%h exp=%h", c, Q, ew); end
            tick();
        end
        start = 1'b0; bit_valid = 1'b0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy got=%b exp=0", busy); end
        total++; if (Q !== ew) begin bad++; $display("FAIL retain_q got=%h exp=%h", Q, ew); end
        bit_valid = 1'b1; bit_in = 1'b1; tick(); bit_valid = 1'b0;
        total++; if ({busy, out_valid} !== 2'b00) begin bad++; $display("FAIL idle_bit got=%b exp=00", {busy, out_valid}); end
    endtask

    task automatic test_reset_mid();
        begin_word(1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1; tick();
        end
        bit_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++; if (Q !== '0) begin bad++; $display("FAIL async_q got=%h exp=00", Q); end
        total++; if ({out_valid, busy, parity_err} !== 3'b000)
            begin bad++; $display("FAIL async_flags got=%b exp=000", {out_valid, busy, parity_err}); end
        rst = 1'b1;
        tick();
        capture(8'h5A, 1'b1, 0, 1'b0);
        ew = exp_q.pop_front(); ep = exp_p.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_rst_valid got=%b exp=1", out_valid); end
        total++; if (Q !== ew) begin bad++; $display("FAIL post_rst_q got=%h exp=%h", Q, ew); end
        // reset while holding must also clear the delivered word
        #2 rst = 1'b0;
        #1;
        total++; if ({Q, out_valid} !== {W'(0), 1'b0}) begin bad++; $display("FAIL hold_rst got=%h/%b exp=00/0", Q, out_valid); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_restart();
        int n;
        begin_word(1'b1);
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; bit_in = i[0] ? 1'b0 : 1'b1; tick();
        end
        exp_q.push_back(8'hC3);
        exp_p.push_back(1'b0);
        start = 1'b1; shift_left = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        start = 1'b0; bit_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b exp=1", busy); end
        total++; if (Q !== '0) begin bad++; $display("FAIL restart_q_kept got=%h exp=00", Q); end
        send_bits(8'hC3, 0);
        send_parity(1'b0);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        ew = exp_q.pop_front(); ep = exp_p.pop_front();
        total++; if (n != 0) begin bad++; $display("FAIL restart_latency got=%0d exp=0", n); end
        total++; if (Q !== ew) begin bad++; $display("FAIL restart_q got=%h exp=%h", Q, ew); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_parity();
        for (int p = 1; p >= 0; p--) begin
            capture(8'hB2, 1'b1, 0, p[0]);
            ew = exp_q.pop_front(); ep = exp_p.pop_front();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL par_valid p=%0d got=%b exp=1", p, out_valid); end
            total++; if (Q !== ew) begin bad++; $display("FAIL par_q p=%0d got=%h exp=%h", p, Q, ew); end
            total++; if (parity_err !== ep) begin bad++; $display("FAIL par_err p=%0d got=%b exp=%b", p, parity_err, ep); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        capture(8'hA1, 1'b0, 0, 1'b1);
        capture_check_release();
        capture(8'h3C, 1'b1, 1, 1'b1);
        capture_check_release();
    endtask

    task automatic capture_check_release();
        ew = exp_q.pop_front(); ep = exp_p.pop_front();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        total++; if (Q !== ew) begin bad++; $display("FAIL b2b_q got=%h exp=%h", Q, ew); end
        total++; if (parity_err !== ep) begin bad++; $display("FAIL b2b_perr got=%b exp=%b", parity_err, ep); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_msb();
        test_lsb();
        test_gaps_hold();
        test_reset_mid();
        test_restart();
        test_parity();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
